// File: rtl/j1_uart_core.sv
// rtl/j1_uart_core.sv - 8N1 UART with register host port; optional error flags via UART_ERR_FLAGS_EN
module j1_uart_core #(
    parameter int CLKS_PER_BIT = 868
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       rx,
    output logic       tx,
    input  logic       wr,
    input  logic       rd,
    input  logic [1:0] adr,
    input  logic [7:0] din,
    output logic [7:0] dout,
    output logic [7:0] dout1
);

    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] HALF = CW'(CLKS_PER_BIT / 2 - 1);

    typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_t;
    typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP, RX_BREAK} rx_state_t;

    tx_state_t     tx_state_q, tx_state_d;
    logic [CW-1:0] tx_cnt_q, tx_cnt_d;
    logic [2:0]    tx_bit_q, tx_bit_d;
    logic [7:0]    tx_shift_q, tx_shift_d;
    logic          tx_q, tx_d;

    rx_state_t     rx_state_q, rx_state_d;
    logic [CW-1:0] rx_cnt_q, rx_cnt_d;
    logic [2:0]    rx_bit_q, rx_bit_d;
    logic [7:0]    rx_shift_q, rx_shift_d;
    logic          rx_s1_q, rx_s2_q;
    logic [7:0]    rx_data_q, rx_data_d;
    logic          rx_ready_q, rx_ready_d;
    logic [7:0]    dout_q, dout_d;

    logic          tx_end, tx_accept, tx_busy;
    logic          rx_done, rx_bad;
    logic          data_rd, stat_rd;
    logic [1:0]    err_bits;
    logic [7:0]    status;
    logic          unused_adr;

    assign unused_adr = adr[0];
    assign data_rd    = rd && !adr[1];
    assign stat_rd    = rd && adr[1];
    assign tx_busy    = (tx_state_q != TX_IDLE);
    assign tx_end     = (tx_cnt_q == LAST);
    // Accepting on the stop-bit end edge gives gapless back-to-back frames.
    assign tx_accept  = wr && !adr[1] &&
                        ((tx_state_q == TX_IDLE) || (tx_state_q == TX_STOP && tx_end));

    always_comb begin
        tx_state_d = tx_state_q;
        tx_cnt_d   = tx_cnt_q;
        tx_bit_d   = tx_bit_q;
        tx_shift_d = tx_shift_q;
        tx_d       = tx_q;
        case (tx_state_q)
            TX_START: begin
                tx_cnt_d = tx_cnt_q + CW'(1);
                if (tx_end) begin
                    tx_cnt_d   = '0;
                    tx_bit_d   = 3'd0;
                    tx_state_d = TX_DATA;
                    tx_d       = tx_shift_q[0];
                end
            end
            TX_DATA: begin
                tx_cnt_d = tx_cnt_q + CW'(1);
                if (tx_end) begin
                    tx_cnt_d = '0;
                    if (tx_bit_q == 3'd7) begin
                        tx_state_d = TX_STOP;
                        tx_d       = 1'b1;
                    end else begin
                        tx_bit_d   = tx_bit_q + 3'd1;
                        tx_shift_d = {1'b0, tx_shift_q[7:1]};
                        tx_d       = tx_shift_q[1];
                    end
                end
            end
            TX_STOP: begin
                tx_cnt_d = tx_cnt_q + CW'(1);
                if (tx_end) begin
                    tx_cnt_d   = '0;
                    tx_state_d = TX_IDLE;
                end
            end
            default: ;
        endcase
        if (tx_accept) begin
            tx_state_d = TX_START;
            tx_cnt_d   = '0;
            tx_shift_d = din;
            tx_d       = 1'b0;
        end
    end

    always_comb begin
        rx_state_d = rx_state_q;
        rx_cnt_d   = rx_cnt_q;
        rx_bit_d   = rx_bit_q;
        rx_shift_d = rx_shift_q;
        rx_done    = 1'b0;
        rx_bad     = 1'b0;
        case (rx_state_q)
            RX_IDLE: begin
                if (!rx_s2_q) begin
                    rx_state_d = RX_START;
                    rx_cnt_d   = '0;
                end
            end
            RX_START: begin
                rx_cnt_d = rx_cnt_q + CW'(1);
                if (rx_cnt_q == HALF) begin
                    rx_cnt_d   = '0;
                    rx_bit_d   = 3'd0;
                    rx_state_d = rx_s2_q ? RX_IDLE : RX_DATA;
                end
            end
            RX_DATA: begin
                rx_cnt_d = rx_cnt_q + CW'(1);
                if (rx_cnt_q == LAST) begin
                    rx_cnt_d   = '0;
                    rx_shift_d = {rx_s2_q, rx_shift_q[7:1]};
                    if (rx_bit_q == 3'd7) rx_state_d = RX_STOP;
                    else                  rx_bit_d   = rx_bit_q + 3'd1;
                end
            end
            RX_STOP: begin
                rx_cnt_d = rx_cnt_q + CW'(1);
                if (rx_cnt_q == LAST) begin
                    rx_cnt_d = '0;
                    if (rx_s2_q) begin
                        rx_done    = 1'b1;
                        rx_state_d = RX_IDLE;
                    end else begin
                        rx_bad     = 1'b1;
                        rx_state_d = RX_BREAK;
                    end
                end
            end
            RX_BREAK: begin
                if (rx_s2_q) rx_state_d = RX_IDLE;
            end
            default: rx_state_d = RX_IDLE;
        endcase
    end

`ifdef UART_ERR_FLAGS_EN
    logic frame_err_q, overrun_q;
    // An overwrite only counts when the old byte was not read in the same cycle.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            frame_err_q <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            frame_err_q <= rx_bad || (frame_err_q && !stat_rd);
            overrun_q   <= (rx_done && rx_ready_q && !data_rd) || (overrun_q && !stat_rd);
        end
    end
    assign err_bits = {overrun_q, frame_err_q};
`else
    assign err_bits = 2'b00;
`endif

    assign status = {4'b0000, err_bits, tx_busy, rx_ready_q};

    always_comb begin
        rx_data_d  = rx_done ? rx_shift_q : rx_data_q;
        rx_ready_d = rx_ready_q;
        if (rx_done)      rx_ready_d = 1'b1;
        else if (data_rd) rx_ready_d = 1'b0;
        dout_d = dout_q;
        if (data_rd)      dout_d = rx_data_q;
        else if (stat_rd) dout_d = status;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            tx_state_q <= TX_IDLE;
            tx_cnt_q   <= '0;
            tx_bit_q   <= 3'd0;
            tx_shift_q <= 8'h00;
            tx_q       <= 1'b1;
            rx_state_q <= RX_IDLE;
            rx_cnt_q   <= '0;
            rx_bit_q   <= 3'd0;
            rx_shift_q <= 8'h00;
            rx_s1_q    <= 1'b1;
            rx_s2_q    <= 1'b1;
            rx_data_q  <= 8'h00;
            rx_ready_q <= 1'b0;
            dout_q     <= 8'h00;
        end else begin
            tx_state_q <= tx_state_d;
            tx_cnt_q   <= tx_cnt_d;
            tx_bit_q   <= tx_bit_d;
            tx_shift_q <= tx_shift_d;
            tx_q       <= tx_d;
            rx_state_q <= rx_state_d;
            rx_cnt_q   <= rx_cnt_d;
            rx_bit_q   <= rx_bit_d;
            rx_shift_q <= rx_shift_d;
            rx_s1_q    <= rx;
            rx_s2_q    <= rx_s1_q;
            rx_data_q  <= rx_data_d;
            rx_ready_q <= rx_ready_d;
            dout_q     <= dout_d;
        end
    end

    assign tx    = tx_q;
    assign dout  = dout_q;
    assign dout1 = rx_data_q;

endmodule

// File: tb/tb_j1_uart_core.sv
// tb/tb_j1_uart_core.sv - self-checking bench for j1_uart_core; honours UART_ERR_FLAGS_EN
module tb_j1_uart_core;
    localparam int CPB = 16;
`ifdef UART_ERR_FLAGS_EN
    localparam logic [7:0] FE = 8'h04;
    localparam logic [7:0] OV = 8'h08;
`else
    localparam logic [7:0] FE = 8'h00;
    localparam logic [7:0] OV = 8'h00;
`endif

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       rx, tx;
    logic       wr = 1'b0, rd = 1'b0;
    logic [1:0] adr = 2'b00;
    logic [7:0] din = 8'h00;
    logic [7:0] dout, dout1;
    logic       loop_en = 1'b0, rx_drv = 1'b1;

    int checks = 0;
    int failures = 0;

    assign rx = loop_en ? tx : rx_drv;
    always #5 clk = ~clk;

    j1_uart_core #(.CLKS_PER_BIT(CPB)) dut (
        .clk(clk), .rst_n(rst_n), .rx(rx), .tx(tx), .wr(wr), .rd(rd),
        .adr(adr), .din(din), .dout(dout), .dout1(dout1)
    );

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h expected=0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Transmitter model: a frame is a 10-bit vector replayed for CPB cycles per bit.
    bit       m_active = 1'b0;
    int       m_pos = 0;
    logic [9:0] m_frame = 10'h3FF;
    bit       m_stat_pending = 1'b0;
    bit       m_exp_busy = 1'b0;

    always @(posedge clk) begin
        m_stat_pending = 1'b0;
        if (!rst_n) begin
            m_active = 1'b0;
            m_pos    = 0;
        end else begin
            if (rd && adr[1]) begin
                m_stat_pending = 1'b1;
                m_exp_busy     = m_active;
            end
            if (wr && !adr[1] && (!m_active || m_pos == 10 * CPB - 1)) begin
                m_frame  = {1'b1, din, 1'b0};
                m_pos    = 0;
                m_active = 1'b1;
            end else if (m_active) begin
                m_pos++;
                if (m_pos == 10 * CPB) m_active = 1'b0;
            end
        end
    end

    always @(negedge clk) begin
        if (rst_n) begin
            check("tx_line", {15'd0, tx}, {15'd0, (m_active ? m_frame[m_pos / CPB] : 1'b1)});
            if (m_stat_pending) check("status_busy", {15'd0, dout[1]}, {15'd0, m_exp_busy});
        end
    end

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic host_write(input logic [7:0] b);
        wr = 1'b1; adr = 2'b00; din = b;
        @(negedge clk);
        wr = 1'b0;
    endtask

    task automatic host_read(input logic a1, output logic [7:0] v);
        rd = 1'b1; adr = {a1, 1'b0};
        @(negedge clk);
        rd = 1'b0; adr = 2'b00;
        v = dout;
    endtask

    task automatic send_frame(input logic [7:0] b, input logic stop);
        rx_drv = 1'b0;
        idle(CPB);
        for (int i = 0; i < 8; i++) begin
            rx_drv = b[i];
            idle(CPB);
        end
        rx_drv = stop;
        idle(CPB);
        rx_drv = 1'b1;
    endtask

    initial begin
        logic [7:0] v;
        logic [7:0] b;
        logic [9:0] pat;
        logic [7:0] lb [2];
        pat = 10'b1001110100;
        lb[0] = 8'h3A;
        lb[1] = 8'h0D;

        idle(3);
        rst_n = 1'b1;
        check("reset_tx", {15'd0, tx}, 16'd1);
        check("reset_dout", {8'd0, dout}, 16'h00);
        check("reset_dout1", {8'd0, dout1}, 16'h00);
        host_read(1'b1, v);
        check("reset_status", {8'd0, v}, 16'h00);

        // Frame shape for 0x3A sampled at bit centres; a write mid-frame must be ignored.
        host_write(8'h3A);
        idle(8);
        for (int k = 0; k < 10; k++) begin
            check("tx_pattern", {15'd0, tx}, {15'd0, pat[k]});
            if (k == 2) begin
                host_write(8'hC3);
                idle(CPB - 1);
            end else begin
                idle(CPB);
            end
        end
        idle(20);

        host_write(8'h00);
        host_read(1'b1, v);
        check("busy_first", {8'd0, v & 8'h02}, 16'h02);
        idle(10 * CPB - 2);
        host_read(1'b1, v);
        check("busy_last", {8'd0, v & 8'h02}, 16'h02);
        host_read(1'b1, v);
        check("busy_clear", {8'd0, v & 8'h02}, 16'h00);

        host_write(8'h5A);
        idle(10 * CPB - 1);
        host_write(8'hA5);
        check("b2b_start", {15'd0, tx}, 16'd0);
        idle(10 * CPB + 10);

        loop_en = 1'b1;
        for (int i = 0; i < 2; i++) begin
            host_write(lb[i]);
            idle(10 * CPB + 10);
            host_read(1'b1, v);
            check("loop_ready", {8'd0, v}, 16'h01);
            host_read(1'b0, v);
            check("loop_data", {8'd0, v}, {8'd0, lb[i]});
            host_read(1'b1, v);
            check("loop_ready_clr", {8'd0, v}, 16'h00);
        end
        loop_en = 1'b0;
        idle(5);

        rx_drv = 1'b0;
        idle(1);
        rx_drv = 1'b1;
        idle(40);
        host_read(1'b1, v);
        check("glitch_status", {8'd0, v}, 16'h00);

        send_frame(8'h55, 1'b0);
        idle(20);
        check("badstop_dout1", {8'd0, dout1}, 16'h0D);
        host_read(1'b1, v);
        check("badstop_status", {8'd0, v}, {8'd0, FE});
        host_read(1'b1, v);
        check("badstop_status2", {8'd0, v}, 16'h00);

        send_frame(8'h41, 1'b1);
        send_frame(8'h42, 1'b1);
        idle(20);
        check("overrun_dout1", {8'd0, dout1}, 16'h42);
        host_read(1'b1, v);
        check("overrun_status", {8'd0, v}, {8'd0, 8'h01 | OV});
        host_read(1'b0, v);
        check("overrun_data", {8'd0, v}, 16'h42);
        host_read(1'b1, v);
        check("overrun_status2", {8'd0, v}, 16'h00);

        for (int i = 0; i < 8; i++) begin
            b = 8'($urandom);
            idle($urandom_range(0, 30));
            send_frame(b, 1'b1);
            idle(10);
            host_read(1'b1, v);
            check("rand_rx_status", {8'd0, v}, 16'h01);
            host_read(1'b0, v);
            check("rand_rx_data", {8'd0, v}, {8'd0, b});
        end

        for (int i = 0; i < 3000; i++) begin
            wr  = ($urandom_range(0, 15) == 0);
            rd  = ($urandom_range(0, 7) == 0);
            adr = 2'($urandom);
            din = 8'($urandom);
            @(negedge clk);
        end
        wr = 1'b0; rd = 1'b0; adr = 2'b00;
        idle(10 * CPB + 5);

        host_write(8'h81);
        idle(50);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        check("midreset_tx", {15'd0, tx}, 16'd1);
        check("midreset_dout", {8'd0, dout}, 16'h00);
        check("midreset_dout1", {8'd0, dout1}, 16'h00);
        host_read(1'b1, v);
        check("midreset_status", {8'd0, v}, 16'h00);
        idle(20);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/j1_uart_core.md
# j1_uart_core

Byte-wide 8N1 UART peripheral with a register-style host port. It serialises bytes written by a host onto `tx` and deserialises frames from `rx` into a one-byte receive holding register. It also exposes a status register. It is the console UART attached to the j1 CPU's I/O bus, and the same block serves as the host-side terminal model in system simulation.

## Interface
- `CLKS_PER_BIT`, default 868 (100 MHz / 115200): clock cycles per bit; legal values are ≥ 4.
- `clk` input, 1 bit: single clock; all logic is rising-edge.
- `rst_n` input, 1 bit: reset, synchronous and active-low.
- `rx` input, 1 bit: serial in, idle high.
- `tx` output, 1 bit: serial out, idle high.
- `wr` input, 1 bit: write strobe, one cycle.
- `rd` input, 1 bit: read strobe, one cycle.
- `adr` input, 2 bits: `adr[1]`=0 selects the data register; `adr[1]`=1 selects the status register; `adr[0]` is ignored.
- `din` input, 8 bits: write data (tx byte).
- `dout` output, 8 bits: registered read data.
- `dout1` output, 8 bits: non-destructive, continuous copy of the rx holding register.

## Operation
- Status byte: bit0 `rx_ready` (holding register full); bit1 `tx_busy`; bits 3:2 per Configuration; bits 7:4 are 0.
- Write with `adr[1]`=0 while `tx_busy`=0 loads `din` and starts a frame. Writes while busy, and writes to the status register, are ignored.
- Read with `adr[1]`=0 returns the holding register and clears `rx_ready`. Read with `adr[1]`=1 returns the status byte.
- TX FSM: IDLE → START → DATA (8 bits, LSB first) → STOP → IDLE. Each state or bit lasts `CLKS_PER_BIT` cycles.
- RX path:
  - `rx` passes through a 2-flop synchroniser.
  - RX FSM: IDLE → START → DATA → STOP → IDLE.
  - A falling edge in IDLE enters START. The line is re-checked at the half-bit point; if it is high, the FSM returns to IDLE (glitch).
  - Data and stop bits are sampled at bit centres.
  - A valid stop bit (1) writes the byte to the holding register and sets `rx_ready`.
  - An invalid stop bit (0) discards the byte. RX then waits for `rx` high before returning to IDLE.
- Overrun: a new valid byte while `rx_ready`=1 overwrites the holding register.
- Simultaneous events:
  - A data read and a byte completion in the same cycle: `dout` returns the old byte, the new byte is stored, and `rx_ready` stays 1.
  - `rd` and `wr` in the same cycle are both serviced.

## Timing
- Reset values: `tx`=1, `dout`=0, `dout1`=0, `rx_ready`=0, `tx_busy`=0, both FSMs in IDLE, counters at 0.
- Reset asserted mid-frame aborts the frame. `tx` returns high on the next edge.
- `dout` updates on the edge where `rd`=1 is sampled and holds otherwise.
- An accepted write sets `tx_busy` and drives the start bit (`tx`=0) on the same edge.
- `tx_busy` stays high for 10×`CLKS_PER_BIT` cycles and clears on the edge that ends the stop bit. A write is accepted on that same clear edge, giving back-to-back frames.
- RX latency: `rx_ready` sets about 2 + 9.5×`CLKS_PER_BIT` cycles after the start-bit falling edge (the stop-bit centre). `dout1` updates on the same edge.

## Configuration
- `UART_ERR_FLAGS_EN` defined:
  - Status bit2 `frame_err` sets on a bad stop bit.
  - Status bit3 `overrun` sets on an overwrite of the holding register.
  - Both are sticky and clear on a status read; a set event in the same cycle wins over the clear.
- `UART_ERR_FLAGS_EN` not defined: bits 3:2 read 0, and the error logic is not built. Behaviour is otherwise identical.

## Test plan
- Reset with `CLKS_PER_BIT`=16 → `tx`=1, status read returns 0x00, `dout1`=0.
- Write 0x3A → `tx` shows 0,0,1,0,1,1,1,0,0,1 for 16 cycles each. `tx_busy` is 1 for 160 cycles. A second write during that time is ignored.
- Loopback `tx`→`rx`, send ":" (0x3A) then CR (0x0D) → each byte is read back correctly. Status bit0 is 1 before each data read and 0 after it.
- 1-cycle low glitch on idle `rx` → no byte, `rx_ready` stays 0.
- Frame 0x55 with stop bit 0 → no `rx_ready`. With `UART_ERR_FLAGS_EN`, status reads 0x04, then 0x00 on the next status read.
- Two bytes 0x41, 0x42 with no read between → data read returns 0x42. With `UART_ERR_FLAGS_EN`, status bit3 is 1.
